// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_pkg;

  localparam int WORD_BITS   = 32;
  localparam int WORD_BYTES  = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } memstate_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 word storage: synchronous write port, combinational read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        idx,
  input  logic [WORD_BITS-1:0] wd,
  output logic [WORD_BITS-1:0] rd
);

  logic [WORD_BITS-1:0] mem [DEPTH];

  // NOTE: storage has no reset; clearing it would force a flop array instead of a RAM.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  assign rd = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait latency, rdy pulse and
// address error detection, fronting a word-addressed storage array.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rdy,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  memstate_t   state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_done;
  logic        accept;

  logic        lat_we;
  logic [31:0] lat_adr;
  logic [31:0] lat_wd;

  logic        txn_we;
  logic [31:0] txn_adr;
  logic [31:0] txn_wd;
  logic        txn_err;
  logic        mem_we;
  logic [AW-1:0]        idx;
  logic [WORD_BITS-1:0] rd;

  assign accept = (state == IDLE) && req;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY = 1 the commit edge is also the acceptance edge, so the live inputs
  // must be used before they have been latched.
  assign txn_we  = (state == IDLE) ? we        : lat_we;
  assign txn_adr = (state == IDLE) ? adr       : lat_adr;
  assign txn_wd  = (state == IDLE) ? writedata : lat_wd;

  assign txn_err = (txn_adr[1:0] != 2'b00) || ((txn_adr >> (AW + 2)) != 32'd0);
  assign idx     = txn_adr[AW+1:2];

  // A request sampled while reset is held must never reach the array.
  assign mem_we  = reset && enter_done && txn_we && !txn_err;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk (clk),
    .we  (mem_we),
    .idx (idx),
    .wd  (txn_wd),
    .rd  (rd)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_adr  <= 32'd0;
      lat_wd   <= 32'd0;
      readdata <= 32'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= enter_done && txn_err;
      if (accept) begin
        lat_we  <= we;
        lat_adr <= adr;
        lat_wd  <= writedata;
      end
      if (enter_done && !txn_we) readdata <= txn_err ? 32'd0 : rd;
    end
  end

  assign rdy  = (state == DONE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) driven by directed and
// random transactions, checked against a word-array reference model.
module tb_mem_responder;

  localparam int LAT [3] = '{2, 1, 15};
  localparam int DEPTH   = 256;

  logic        clk;
  logic        reset;
  logic        req       [3];
  logic        we        [3];
  logic [31:0] adr       [3];
  logic [31:0] writedata [3];
  logic [31:0] readdata  [3];
  logic        rdy       [3];
  logic        err       [3];
  logic        busy      [3];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mdl    [3][DEPTH];
  bit          known  [3][DEPTH];
  logic [31:0] rd_mdl [3];

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT[0])) u_l2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .adr(adr[0]),
    .writedata(writedata[0]), .readdata(readdata[0]), .rdy(rdy[0]),
    .err(err[0]), .busy(busy[0]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT[1])) u_l1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .adr(adr[1]),
    .writedata(writedata[1]), .readdata(readdata[1]), .rdy(rdy[1]),
    .err(err[1]), .busy(busy[1]));

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT[2])) u_l15 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .adr(adr[2]),
    .writedata(writedata[2]), .readdata(readdata[2]), .rdy(rdy[2]),
    .err(err[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request: drive, scramble inputs after acceptance, wait for rdy,
  // then compare latency, busy time, err and readdata against the model.
  task automatic do_txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    int          c;
    int          busy_cyc;
    bit          got;
    bit          exp_err;
    int          wi;
    logic [31:0] exp_rd;
    exp_err = (a % 4 != 0) || (a >= DEPTH * 4);
    wi      = int'((a / 4) % DEPTH);
    @(negedge clk);
    check("idle_busy", {31'b0, busy[k]}, 32'd0);
    check("idle_rdy", {31'b0, rdy[k]}, 32'd0);
    req[k] = 1'b1; we[k] = w; adr[k] = a; writedata[k] = d;
    @(posedge clk);
    #1;
    we[k] = 1'($urandom); adr[k] = $urandom; writedata[k] = $urandom;
    c = 0; busy_cyc = 0; got = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (busy[k]) busy_cyc++;
      if (rdy[k]) got = 1;
    end
    check("rdy_latency", c, LAT[k]);
    check("busy_cycles", busy_cyc, LAT[k]);
    check("err", {31'b0, err[k]}, {31'b0, exp_err});
    if (w) begin
      check("rd_hold_on_write", readdata[k], rd_mdl[k]);
      if (!exp_err) begin
        mdl[k][wi]   = d;
        known[k][wi] = 1'b1;
      end
    end else begin
      exp_rd = exp_err ? 32'd0 : mdl[k][wi];
      if (exp_err || known[k][wi]) check("readdata", readdata[k], exp_rd);
      rd_mdl[k] = exp_rd;
    end
    req[k] = 1'b0;
  endtask

  initial begin
    int          last;
    int          cur;
    bit          prev_rdy;
    int          r;
    logic [31:0] a;
    logic [31:0] p;

    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 0; we[k] = 0; adr[k] = 0; writedata[k] = 0; rd_mdl[k] = 32'd0;
      for (int i = 0; i < DEPTH; i++) known[k][i] = 1'b0;
    end

    // Power-on reset
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_rdy", {31'b0, rdy[k]}, 32'd0);
      check("reset_busy", {31'b0, busy[k]}, 32'd0);
      check("reset_err", {31'b0, err[k]}, 32'd0);
      check("reset_readdata", readdata[k], 32'd0);
    end
    reset = 1'b1;

    // Basic write/read at LATENCY 2
    do_txn(0, 1, 32'h10, 32'hDEAD_BEEF);
    do_txn(0, 0, 32'h10, 32'h0);
    check("deadbeef", readdata[0], 32'hDEAD_BEEF);

    // Fill the whole LATENCY 2 array with random words
    for (int i = 0; i < DEPTH; i++) do_txn(0, 1, 32'(i * 4), $urandom);

    // Misaligned read, out-of-range write aliasing word 0, then word 0 unchanged
    do_txn(0, 0, 32'h13, 32'h0);
    do_txn(0, 1, 32'h400, 32'hBAD0_BAD0);
    do_txn(0, 0, 32'h0, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
      do_txn(0, 1'($urandom), a, $urandom);
    end

    // Read-after-write in consecutive transactions
    do_txn(0, 1, 32'h84, 32'h0BAD_F00D);
    do_txn(0, 0, 32'h84, 32'h0);

    // LATENCY 1 and LATENCY 15
    do_txn(1, 1, 32'h20, 32'h1111_2222);
    do_txn(1, 0, 32'h20, 32'h0);
    do_txn(1, 1, 32'h20, 32'h3333_4444);
    do_txn(1, 0, 32'h20, 32'h0);
    do_txn(1, 0, 32'h21, 32'h0);
    do_txn(2, 1, 32'h30, 32'hCAFE_F00D);
    do_txn(2, 0, 32'h30, 32'h0);

    // Requests held continuously: one acceptance every LATENCY+1 cycles
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h40;
    last = -1; cur = 0; prev_rdy = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (prev_rdy) check("hold_done_no_accept", {31'b0, busy[0]}, 32'd0);
      prev_rdy = rdy[0];
      if (rdy[0]) begin
        check("hold_readdata", readdata[0], mdl[0][cur == 0 ? 16 : 17]);
        check("hold_err", {31'b0, err[0]}, 32'd0);
        if (last >= 0) check("hold_period", c - last, LAT[0] + 1);
        last = c;
        cur  = 1 - cur;
        adr[0] = (cur == 0) ? 32'h40 : 32'h44;
      end
    end
    req[0] = 1'b0;
    check("hold_saw_rdy", {31'b0, last >= 0}, 32'd1);
    repeat (4) @(negedge clk);

    // Reset in the middle of a LATENCY 15 write discards it
    p = 32'hA5A5_0001;
    do_txn(2, 1, 32'h20, p);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; writedata[2] = 32'h1234_5678;
    @(posedge clk);
    repeat (5) @(negedge clk);
    check("midreset_busy_before", {31'b0, busy[2]}, 32'd1);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("midreset_rdy", {31'b0, rdy[k]}, 32'd0);
      check("midreset_busy", {31'b0, busy[k]}, 32'd0);
      check("midreset_readdata", readdata[k], 32'd0);
      rd_mdl[k] = 32'd0;
    end
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    do_txn(2, 0, 32'h20, 32'h0);
    check("write_discarded", readdata[2], p);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
